// File: rtl/des_dma_pkg.sv
// rtl/des_dma_pkg.sv - shared types and constants for the DES output DMA
// Purpose: FSM state encoding and the byte strides used by the address counter.
// Ports: none (package).
package des_dma_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD   = 3'd1,
    WR_LO  = 3'd2,
    WR_HI  = 3'd3,
    FINISH = 3'd4
  } dma_state_t;

  localparam int WORD_BYTES  = 4;
  localparam int BLOCK_BYTES = 8;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock block FIFO with registered read data
// Purpose: buffers encrypted blocks between the upstream stream and the writer.
// Ports:
//   clk, reset_n     clock, asynchronous active-low reset
//   push, din        write request and data (ignored while full)
//   pop              read request (ignored while empty); dout updates on the next edge
//   dout             registered read data, stable between pops
//   full, empty      occupancy flags, evaluated before this cycle's push/pop
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      count;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // Storage carries no reset; only pointers and count define the contents.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      dout   <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
        dout   <= mem[rd_ptr];
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/des_output_dma.sv
// rtl/des_output_dma.sv - writes 64-bit encrypted blocks to memory as two 32-bit Avalon beats
// Purpose: software latches base_addr/num_blocks with a start pulse; the block stream is
//   buffered, then each block is written low word first at consecutive word addresses.
// Ports:
//   clk, reset_n                         clock, asynchronous active-low reset
//   start, base_addr, num_blocks         transfer request, sampled only in IDLE
//   blk_data, blk_valid, blk_ready       encrypted block stream
//   master_address/writedata/write       Avalon-MM write master
//   master_waitrequest                   Avalon slave stall
//   busy, done, blocks_written           status for the CSR block
module des_output_dma
  import des_dma_pkg::*;
#(
  parameter int MASTER_ADDRESSWIDTH = 26,
  parameter int DATAWIDTH           = 32,
  parameter int BLOCKWIDTH          = 64,
  parameter int LENWIDTH            = 14,
  parameter int FIFO_DEPTH          = 4
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           start,
  input  logic [MASTER_ADDRESSWIDTH-1:0] base_addr,
  input  logic [LENWIDTH-1:0]            num_blocks,
  input  logic [BLOCKWIDTH-1:0]          blk_data,
  input  logic                           blk_valid,
  output logic                           blk_ready,
  output logic [MASTER_ADDRESSWIDTH-1:0] master_address,
  output logic [DATAWIDTH-1:0]           master_writedata,
  output logic                           master_write,
  input  logic                           master_waitrequest,
  output logic                           busy,
  output logic                           done,
  output logic [LENWIDTH-1:0]            blocks_written
);

  dma_state_t                     state;
  dma_state_t                     state_next;
  logic [MASTER_ADDRESSWIDTH-1:0] cur_addr;
  logic [LENWIDTH-1:0]            num_lat;
  logic [LENWIDTH-1:0]            accepted;
  logic [BLOCKWIDTH-1:0]          hold;
  logic                           fifo_full;
  logic                           fifo_empty;
  logic                           push;
  logic                           pop;

  // The FIFO's registered read port doubles as the hold register: it only
  // changes on a pop, and pops happen only in LOAD.
  sync_fifo #(.WIDTH(BLOCKWIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .pop     (pop),
    .din     (blk_data),
    .dout    (hold),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign busy      = (state == LOAD) || (state == WR_LO) || (state == WR_HI);
  assign done      = (state == FINISH);
  // Separate accept counter keeps upstream from delivering more than num_blocks.
  assign blk_ready = busy && !fifo_full && (accepted < num_lat);
  assign push      = blk_valid && blk_ready;
  assign pop       = (state == LOAD) && !fifo_empty;

  // Avalon outputs decode from state and registers only, so they hold across stalls.
  assign master_write     = (state == WR_LO) || (state == WR_HI);
  assign master_address   = (state == WR_LO) ? cur_addr :
                            (state == WR_HI) ? cur_addr + MASTER_ADDRESSWIDTH'(WORD_BYTES) : '0;
  assign master_writedata = (state == WR_LO) ? hold[DATAWIDTH-1:0] :
                            (state == WR_HI) ? hold[BLOCKWIDTH-1:DATAWIDTH] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = (num_blocks == '0) ? FINISH : LOAD;
      LOAD:    if (!fifo_empty) state_next = WR_LO;
      WR_LO:   if (!master_waitrequest) state_next = WR_HI;
      WR_HI:   if (!master_waitrequest)
                 state_next = (blocks_written + 1'b1 == num_lat) ? FINISH : LOAD;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_addr       <= '0;
      num_lat        <= '0;
      accepted       <= '0;
      blocks_written <= '0;
    end else begin
      if (state == IDLE && start) begin
        cur_addr       <= base_addr;
        num_lat        <= num_blocks;
        accepted       <= '0;
        blocks_written <= '0;
      end else begin
        if (push) accepted <= accepted + 1'b1;
        if (state == WR_HI && !master_waitrequest) begin
          cur_addr       <= cur_addr + MASTER_ADDRESSWIDTH'(BLOCK_BYTES);
          blocks_written <= blocks_written + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_des_output_dma.sv
// tb/tb_des_output_dma.sv - self-checking bench for des_output_dma
module tb_des_output_dma;

  localparam int AW    = 26;
  localparam int LW    = 14;
  localparam int DEPTH = 4;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [LW-1:0] num_blocks;
  logic [63:0]   blk_data;
  logic          blk_valid;
  logic          blk_ready;
  logic [AW-1:0] master_address;
  logic [31:0]   master_writedata;
  logic          master_write;
  logic          waitreq;
  logic          busy;
  logic          done;
  logic [LW-1:0] blocks_written;

  always #5 clk = ~clk;

  des_output_dma #(
    .MASTER_ADDRESSWIDTH(AW), .DATAWIDTH(32), .BLOCKWIDTH(64),
    .LENWIDTH(LW), .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk                (clk),
    .reset_n            (reset_n),
    .start              (start),
    .base_addr          (base_addr),
    .num_blocks         (num_blocks),
    .blk_data           (blk_data),
    .blk_valid          (blk_valid),
    .blk_ready          (blk_ready),
    .master_address     (master_address),
    .master_writedata   (master_writedata),
    .master_write       (master_write),
    .master_waitrequest (waitreq),
    .busy               (busy),
    .done               (done),
    .blocks_written     (blocks_written)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Beat k of a transfer lands at base + 8*(k/2) + 4*(k%2), wrapping at 2^AW.
  function automatic logic [AW-1:0] exp_addr(input logic [AW-1:0] b, input int k);
    logic [AW-1:0] off;
    off = AW'((k / 2) * 8 + (k % 2) * 4);
    return b + off;
  endfunction

  typedef struct {
    logic [AW-1:0] base;
    int            n;
    int            stall;      // 0 none, 1 three cycles per beat, 2 random
    int            bp;         // cycles of forced waitrequest at the start
    bit            extra;      // offer one block more than n
    bit            restart;    // second start pulse while busy
    bit            fixed_blk;  // first block is 0x11223344_AABBCCDD
    int            exp_bw;
    int            exp_beats;
    int            exp_bp_acc;
  } vec_t;

  task automatic run_xfer(input vec_t v);
    logic [63:0]   blks[$];
    logic [AW-1:0] prev_addr;
    logic [31:0]   prev_data;
    bit            prev_stall;
    int            total, prod, acc, beats, dones, done_cyc, sc, cyc;
    total = v.n + (v.extra ? 1 : 0);
    for (int i = 0; i < total; i++) blks.push_back({$urandom, $urandom});
    if (v.fixed_blk && total > 0) blks[0] = 64'h11223344_AABBCCDD;
    prod = 0; acc = 0; beats = 0; dones = 0; done_cyc = -1; sc = 0;
    prev_stall = 1'b0; prev_addr = '0; prev_data = '0;

    @(negedge clk);
    base_addr = v.base; num_blocks = LW'(v.n); start = 1'b1; blk_valid = 1'b0; waitreq = 1'b0;
    @(negedge clk);
    for (cyc = 0; cyc < 3000; cyc++) begin
      if (v.restart && cyc == 4) begin
        start = 1'b1; base_addr = v.base ^ 26'h5000; num_blocks = LW'(v.n + 3);
      end else begin
        start = 1'b0;
      end
      blk_valid = (prod < total) && (v.stall != 2 || $urandom_range(0, 3) != 0);
      blk_data  = (prod < total) ? blks[prod] : 64'h0;
      #1;
      if (cyc < v.bp) waitreq = 1'b1;
      else if (v.stall == 1 && master_write) begin
        if (sc < 3) begin waitreq = 1'b1; sc++; end
        else begin waitreq = 1'b0; sc = 0; end
      end else if (v.stall == 2) waitreq = 1'($urandom_range(0, 1));
      else waitreq = 1'b0;
      #1;
      if (cyc == 0) chk("busy_after_start", busy, (v.n > 0));
      if (prev_stall) begin
        chk("stall_write_held", master_write, 1);
        chk("stall_addr_held", master_address, prev_addr);
        chk("stall_data_held", master_writedata, prev_data);
      end
      if (master_write && !waitreq) begin
        if (beats < 2 * v.n) begin
          chk("wr_addr", master_address, exp_addr(v.base, beats));
          chk("wr_data", master_writedata,
              (beats % 2) ? blks[beats / 2][63:32] : blks[beats / 2][31:0]);
        end else begin
          chk("extra_beat", beats, 2 * v.n);
        end
        beats++;
      end
      prev_stall = master_write && waitreq;
      prev_addr  = master_address;
      prev_data  = master_writedata;
      if (blk_valid && blk_ready) begin acc++; prod++; end
      if (v.bp > 0 && cyc == v.bp - 1) begin
        chk("bp_accepts", acc, v.exp_bp_acc);
        chk("bp_ready_low", blk_ready, 0);
      end
      if (done) begin
        dones++;
        if (done_cyc < 0) done_cyc = cyc;
        chk("bw_at_done", blocks_written, v.exp_bw);
        chk("busy_at_done", busy, 0);
      end
      @(negedge clk);
      if (done_cyc >= 0 && cyc >= done_cyc + 3) break;
    end
    blk_valid = 1'b0; waitreq = 1'b0; start = 1'b0;
    chk("done_count", dones, 1);
    chk("beats_total", beats, v.exp_beats);
    chk("accepts_total", acc, v.exp_bw);
    chk("bw_final", blocks_written, v.exp_bw);
    chk("busy_final", busy, 0);
    if (v.n == 0) chk("n0_done_latency", done_cyc, 0);
  endtask

  vec_t vecs[$];
  vec_t rv;

  initial begin
    reset_n = 1'b0; start = 1'b0; base_addr = '0; num_blocks = '0;
    blk_data = '0; blk_valid = 1'b0; waitreq = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_write", master_write, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_ready", blk_ready, 0);
    chk("rst_bw", blocks_written, 0);
    reset_n = 1'b1;

    // Reset asserted while a stalled low beat is on the bus.
    @(negedge clk);
    base_addr = 26'h200; num_blocks = 14'd2; start = 1'b1;
    blk_valid = 1'b1; blk_data = 64'hDEAD_BEEF_0123_4567; waitreq = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 10 && !master_write; i++) @(negedge clk);
    chk("rst_reach_wr_lo", master_write, 1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_write", master_write, 0);
    chk("mid_rst_addr", master_address, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_ready", blk_ready, 0);
    chk("mid_rst_bw", blocks_written, 0);
    @(negedge clk);
    blk_valid = 1'b0; waitreq = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    //                base          n  stl bp  ext rst fix bw beats bpacc
    vecs.push_back('{26'h100,     1, 0, 0,  0,  0,  1,  1,  2,  0});
    vecs.push_back('{26'h1000,    3, 1, 0,  0,  0,  0,  3,  6,  0});
    vecs.push_back('{26'h2000,    8, 0, 20, 1,  0,  0,  8, 16,  5});
    vecs.push_back('{26'h0,       0, 0, 0,  0,  0,  0,  0,  0,  0});
    vecs.push_back('{26'h3FFFFF8, 2, 0, 0,  0,  0,  0,  2,  4,  0});
    vecs.push_back('{26'h300,     4, 0, 0,  0,  1,  0,  4,  8,  0});
    vecs.push_back('{26'h40,      6, 2, 0,  0,  0,  0,  6, 12,  0});
    for (int i = 0; i < vecs.size(); i++) run_xfer(vecs[i]);

    for (int r = 0; r < 6; r++) begin
      rv.base       = AW'($urandom);
      rv.n          = $urandom_range(1, 10);
      rv.stall      = $urandom_range(0, 2);
      rv.bp         = 0;
      rv.extra      = 1'($urandom_range(0, 1));
      rv.restart    = 1'b0;
      rv.fixed_blk  = 1'b0;
      rv.exp_bw     = rv.n;
      rv.exp_beats  = 2 * rv.n;
      rv.exp_bp_acc = 0;
      run_xfer(rv);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
